pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Parametrised successor to the single-register PC. It holds the fetch PC, issues instruction-fetch requests over a valid/ready handshake and advances sequentially on each accepted fetch. It arbitrates NUM_REDIR prioritised redirect sources (exception, eret, branch/jump) and buffers a redirect that arrives during a stall. It sits between the pipeline hazard/exception logic and the instruction-memory interface.

Parameters:
ADDR_W, 32, PC width in bits
RESET_VEC, 32'hBFC00000, PC value after reset
INST_BYTES, 4, sequential increment; power of two
NUM_REDIR, 3, number of redirect sources; index 0 = highest priority (exception)
BOOT_CYCLES, 4, cycles that fetch is suppressed after reset release; 0 = none

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
en  in  1  pipeline advance enable (0 = stall)
redir_valid  in  NUM_REDIR  per-source redirect request
redir_pc  in  NUM_REDIR*ADDR_W  redirect targets; source i at bits [i*ADDR_W +: ADDR_W]
req_ready  in  1  instruction memory accepts request
req_valid  out  1  fetch request valid
req_addr  out  ADDR_W  fetch address (= q)
q  out  ADDR_W  current PC
pend_valid  out  1  a stalled redirect is buffered
addr_err  out  1  q misaligned to INST_BYTES
redir_taken  out  1  one-cycle pulse: q was loaded from a redirect on the previous edge

Behaviour:
- Reset (rst=0, asynchronous): q=RESET_VEC, state=BOOT (RUN if BOOT_CYCLES=0), boot counter=0, pend_valid=0, pend_pc=0, redir_taken=0, req_valid=0, addr_err=0. Reset asserted mid-operation aborts everything, including buffered redirects.
- FSM BOOT: req_valid=0 and redirects are ignored. Counter increments each cycle; at count BOOT_CYCLES-1 the next state is RUN.
- FSM RUN: req_valid = ~addr_err. req_addr=q (combinational).
- addr_err = (q mod INST_BYTES != 0), combinational. While it is set, no requests are issued and only a redirect clears it.
- sel = lowest index i with redir_valid[i]=1. Selection is combinational, via the sub-module.
- RUN next-state priority, evaluated each edge:
  1. sel==0: q<=redir_pc[0] regardless of en; pend_valid<=0.
  2. en=1, sel exists: q<=redir_pc[sel]; pend_valid<=0. A new redirect beats a buffered one.
  3. en=1, pend_valid=1: q<=pend_pc; pend_valid<=0.
  4. en=1, req_valid&req_ready: q<=q+INST_BYTES, modulo 2^ADDR_W (wraps to 0, no flag).
  5. en=0, sel>0 exists: pend_pc<=redir_pc[sel], pend_valid<=1, overwriting any older pending entry; q holds.
  6. Otherwise q holds.
- A redirect in the same cycle as an accepted fetch: the redirect wins. The accepted request is still issued, and the consumer discards it on redir_taken.
- redir_taken<=1 on the edge after cases 1–3 load q; otherwise 0.
- Latency: redirect to req_addr is 1 cycle (en=1) or 1 cycle after en returns (buffered). Sequential advance is 1 cycle per handshake.

Decomposition:
- pc_pkg: state enum {BOOT, RUN}, default RESET_VEC, INST_BYTES, and a function for increment alignment-mask width.
- Sub-module pc_redir_sel: fixed-priority encoder over NUM_REDIR, outputting any/sel_idx/sel_pc.

Test Plan:
1. Reset release with BOOT_CYCLES=4, req_ready=1, en=1 -> req_valid=0 for 4 cycles with q=BFC00000; then addresses BFC00000, BFC00004, BFC00008 on consecutive cycles.
2. req_ready=0 for 3 cycles in RUN -> q holds at BFC00008; advances to BFC0000C one cycle after req_ready=1.
3. en=0, redir_valid=3'b100, target 80001000, then en=1 two cycles later -> pend_valid=1 during stall; q=80001000 one cycle after en=1; redir_taken pulses.
4. en=0 with pending 80001000, then redir_valid=3'b001, target BFC00380 -> q=BFC00380 next cycle, pend_valid=0, redir_taken=1.
5. Simultaneous redir_valid=3'b110 (targets 1000/2000) with en=1 -> q=00001000 (index 1 wins).
6. Redirect to 80000002 -> addr_err=1, req_valid=0, q frozen; then redirect 80000100 -> addr_err=0, fetch resumes. Also q=FFFFFFFC with handshake -> q=00000000.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-PC slice.
package pc_pkg;

    typedef enum logic {
        BOOT,
        RUN
    } pc_state_t;

    localparam logic [31:0] DEF_RESET_VEC  = 32'hBFC00000;
    localparam int          DEF_INST_BYTES = 4;

    // Low PC bits that must be zero for an aligned fetch.
    function automatic int align_w(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 0;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_redir_sel.sv
// Fixed-priority pick over redirect sources; index 0 wins.
module pc_redir_sel
    import pc_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int NUM_REDIR = 3,
    parameter int IDX_W     = idx_w(NUM_REDIR)
) (
    input  logic [NUM_REDIR-1:0]        redir_valid,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_pc,
    output logic                        any,
    output logic [IDX_W-1:0]            sel_idx,
    output logic [ADDR_W-1:0]           sel_pc
);

    always_comb begin
        any     = 1'b0;
        sel_idx = '0;
        sel_pc  = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                any     = 1'b1;
                sel_idx = IDX_W'(i);
                sel_pc  = redir_pc[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC: boot hold-off, sequential advance on handshake,
// prioritised redirects with a one-entry stall buffer.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(DEF_RESET_VEC),
    parameter int                INST_BYTES  = DEF_INST_BYTES,
    parameter int                NUM_REDIR   = 3,
    parameter int                BOOT_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NUM_REDIR-1:0]        redir_valid,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_pc,
    input  logic                        req_ready,
    output logic                        req_valid,
    output logic [ADDR_W-1:0]           req_addr,
    output logic [ADDR_W-1:0]           q,
    output logic                        pend_valid,
    output logic                        addr_err,
    output logic                        redir_taken
);

    localparam int IDX_W = idx_w(NUM_REDIR);
    localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST =
        CNT_W'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);
    localparam pc_state_t RST_STATE = (BOOT_CYCLES == 0) ? RUN : BOOT;
    localparam logic [ADDR_W-1:0] ALIGN_MASK =
        ADDR_W'((64'd1 << align_w(INST_BYTES)) - 64'd1);

    pc_state_t         state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] q_n;
    logic [ADDR_W-1:0] pend_pc, pend_pc_n;
    logic              pend_n, taken_n;

    logic              any;
    logic [IDX_W-1:0]  sel_idx;
    logic [ADDR_W-1:0] sel_pc;
    logic              sel_hi;

    pc_redir_sel #(
        .ADDR_W    (ADDR_W),
        .NUM_REDIR (NUM_REDIR),
        .IDX_W     (IDX_W)
    ) u_sel (
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .any         (any),
        .sel_idx     (sel_idx),
        .sel_pc      (sel_pc)
    );

    assign sel_hi    = any && (sel_idx == '0);
    assign addr_err  = |(q & ALIGN_MASK);
    assign req_valid = (state == RUN) && !addr_err;
    assign req_addr  = q;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        q_n       = q;
        pend_n    = pend_valid;
        pend_pc_n = pend_pc;
        taken_n   = 1'b0;
        if (state == BOOT) begin
            cnt_n = cnt + 1'b1;
            if (cnt == BOOT_LAST) begin
                state_n = RUN;
            end
        end else if (sel_hi || (en && any)) begin
            // Exceptions load even while stalled.
            q_n     = sel_pc;
            pend_n  = 1'b0;
            taken_n = 1'b1;
        end else if (en && pend_valid) begin
            q_n     = pend_pc;
            pend_n  = 1'b0;
            taken_n = 1'b1;
        end else if (en && req_valid && req_ready) begin
            q_n = q + ADDR_W'(INST_BYTES);
        end else if (!en && any) begin
            pend_pc_n = sel_pc;
            pend_n    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RST_STATE;
            cnt         <= '0;
            q           <= RESET_VEC;
            pend_valid  <= 1'b0;
            pend_pc     <= '0;
            redir_taken <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            q           <= q_n;
            pend_valid  <= pend_n;
            pend_pc     <= pend_pc_n;
            redir_taken <= taken_n;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plan plus random traffic against a behavioural PC model.
module tb_pc_fetch_unit;

    localparam int          AW = 32;
    localparam int          NR = 3;
    localparam int          IB = 4;
    localparam int          BC = 4;
    localparam logic [31:0] RV = 32'hBFC00000;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en = 1'b0;
    logic           req_ready = 1'b0;
    logic [NR-1:0]  redir_valid = '0;
    logic [NR*AW-1:0] redir_pc = '0;
    logic           req_valid;
    logic [AW-1:0]  req_addr;
    logic [AW-1:0]  q;
    logic           pend_valid;
    logic           addr_err;
    logic           redir_taken;

    pc_fetch_unit #(
        .ADDR_W      (AW),
        .RESET_VEC   (RV),
        .INST_BYTES  (IB),
        .NUM_REDIR   (NR),
        .BOOT_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .req_ready   (req_ready),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .q           (q),
        .pend_valid  (pend_valid),
        .addr_err    (addr_err),
        .redir_taken (redir_taken)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_q;
    logic [31:0] m_pend_pc;
    bit          m_pend;
    bit          m_taken;
    int          m_boot;
    logic [31:0] tgt [NR];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_err();
        return (m_q % IB) != 0;
    endfunction

    function automatic bit m_req();
        return (m_boot == 0) && !m_err();
    endfunction

    task automatic model_reset();
        m_q       = RV;
        m_pend    = 0;
        m_pend_pc = 0;
        m_taken   = 0;
        m_boot    = BC;
    endtask

    task automatic cmp_all();
        check("q", q, m_q);
        check("req_addr", req_addr, m_q);
        check("req_valid", 32'(req_valid), 32'(m_req()));
        check("addr_err", 32'(addr_err), 32'(m_err()));
        check("pend_valid", 32'(pend_valid), 32'(m_pend));
        check("redir_taken", 32'(redir_taken), 32'(m_taken));
    endtask

    // Next PC from the rules: exception always, other redirects only
    // when advancing, then the buffered target, then sequential.
    task automatic model_next();
        int s;
        bit fire;
        s = -1;
        for (int i = NR - 1; i >= 0; i--) if (redir_valid[i]) s = i;
        fire = m_req() && req_ready;
        m_taken = 0;
        if (m_boot > 0) begin
            m_boot--;
        end else if (s == 0 || (en && s > 0)) begin
            m_q = tgt[s]; m_pend = 0; m_taken = 1;
        end else if (en && m_pend) begin
            m_q = m_pend_pc; m_pend = 0; m_taken = 1;
        end else if (en && fire) begin
            m_q = m_q + IB;
        end else if (!en && s > 0) begin
            m_pend_pc = tgt[s]; m_pend = 1;
        end
    endtask

    task automatic step(input bit e, input logic [2:0] rv,
                        input logic [31:0] p0, input logic [31:0] p1,
                        input logic [31:0] p2, input bit rdy);
        en          = e;
        redir_valid = rv;
        tgt[0] = p0; tgt[1] = p1; tgt[2] = p2;
        redir_pc    = {p2, p1, p0};
        req_ready   = rdy;
        @(negedge clk);
        cmp_all();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit e, input bit rdy);
        step(e, 3'b000, 32'h0, 32'h0, 32'h0, rdy);
    endtask

    function automatic logic [31:0] rnd_tgt();
        int k;
        k = $urandom_range(0, 7);
        if (k == 0) return 32'hFFFFFFFC;
        if (k == 1) return $urandom() | 32'h1;
        return $urandom() & 32'hFFFFFFFC;
    endfunction

    initial begin
        model_reset();
        #12;
        check("rst_q", q, RV);
        check("rst_req_valid", 32'(req_valid), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        // boot hold-off then sequential fetch
        for (int i = 0; i < BC; i++) idle(1, 1);
        check("t1_q0", req_addr, 32'hBFC00000);
        check("t1_rv", 32'(req_valid), 32'h1);
        idle(1, 1);
        check("t1_q1", q, 32'hBFC00004);
        idle(1, 1);
        check("t1_q2", q, 32'hBFC00008);

        for (int i = 0; i < 3; i++) idle(1, 0);
        check("t2_hold", q, 32'hBFC00008);
        idle(1, 1);
        check("t2_adv", q, 32'hBFC0000C);

        // stalled redirect is buffered then applied
        step(0, 3'b100, 0, 0, 32'h80001000, 1);
        check("t3_pend", 32'(pend_valid), 32'h1);
        check("t3_hold", q, 32'hBFC0000C);
        idle(0, 1);
        idle(1, 1);
        check("t3_q", q, 32'h80001000);
        check("t3_taken", 32'(redir_taken), 32'h1);

        // exception beats a pending redirect during a stall
        step(0, 3'b100, 0, 0, 32'h80001000, 1);
        step(0, 3'b001, 32'hBFC00380, 0, 0, 1);
        check("t4_q", q, 32'hBFC00380);
        check("t4_pend", 32'(pend_valid), 32'h0);
        check("t4_taken", 32'(redir_taken), 32'h1);

        step(1, 3'b110, 0, 32'h00001000, 32'h00002000, 1);
        check("t5_q", q, 32'h00001000);

        // misaligned target freezes fetch until redirected
        step(1, 3'b001, 32'h80000002, 0, 0, 1);
        check("t6_err", 32'(addr_err), 32'h1);
        check("t6_rv", 32'(req_valid), 32'h0);
        idle(1, 1);
        check("t6_frozen", q, 32'h80000002);
        step(1, 3'b001, 32'h80000100, 0, 0, 1);
        check("t6_clear", 32'(addr_err), 32'h0);
        idle(1, 1);
        check("t6_resume", q, 32'h80000104);
        step(1, 3'b010, 0, 32'hFFFFFFFC, 0, 1);
        idle(1, 1);
        check("t6_wrap", q, 32'h00000000);

        for (int c = 0; c < 600; c++) begin
            logic [2:0] rv;
            rv[0] = ($urandom_range(0, 11) == 0);
            rv[1] = ($urandom_range(0, 5) == 0);
            rv[2] = ($urandom_range(0, 4) == 0);
            if (c == 300) begin
                #2 rst = 1'b0;
                #1;
                model_reset();
                check("midrst_q", q, RV);
                check("midrst_pend", 32'(pend_valid), 32'h0);
                check("midrst_taken", 32'(redir_taken), 32'h0);
                @(posedge clk);
                #1 rst = 1'b1;
            end
            step($urandom_range(0, 3) != 0, rv, rnd_tgt(), rnd_tgt(),
                 rnd_tgt(), $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
